// File: rtl/byte_packer_pkg.sv
// Shared widths, pad default and accumulator state encoding for the byte packer.
package byte_packer_pkg;

  localparam int unsigned IN_W_DEFAULT  = 8;
  localparam int unsigned OUT_W_DEFAULT = 32;
  localparam logic [IN_W_DEFAULT-1:0] PAD_DEFAULT = '0;

  typedef enum logic {
    EMPTY   = 1'b0,
    PARTIAL = 1'b1
  } acc_state_t;

  // One tkeep bit per input lane.
  function automatic int unsigned lanes_of(input int unsigned out_w, input int unsigned in_w);
    return out_w / in_w;
  endfunction

endpackage

// File: rtl/byte_packer_outreg.sv
// Output word register: holds a completed word until downstream accepts it and counts transfers.
module byte_packer_outreg
  import byte_packer_pkg::*;
#(
  parameter int unsigned OUT_W = OUT_W_DEFAULT,
  parameter int unsigned LANES = lanes_of(OUT_W_DEFAULT, IN_W_DEFAULT)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [LANES-1:0] load_keep,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             can_load,
  output logic             valid,
  output logic [OUT_W-1:0] tdata,
  output logic [LANES-1:0] tkeep,
  output logic             tlast,
  output logic [15:0]      word_count
);

  logic xfer;

  assign xfer     = valid && out_ready;
  assign can_load = !valid || out_ready;

  // A load on the same edge as a transfer keeps valid high with the new word.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid      <= 1'b0;
      tdata      <= '0;
      tkeep      <= '0;
      tlast      <= 1'b0;
      word_count <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        tdata <= load_data;
        tkeep <= load_keep;
        tlast <= load_last;
      end else if (xfer) begin
        valid <= 1'b0;
      end
      if (xfer) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/byte_packer.sv
// Packs a valid/ready/last byte stream into OUT_W-bit words, padding and flushing short final words.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int unsigned     IN_W  = IN_W_DEFAULT,
  parameter int unsigned     OUT_W = OUT_W_DEFAULT,
  parameter logic [IN_W-1:0] PAD   = '0
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                in_valid,
  input  logic [IN_W-1:0]                     in_data,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic                                valid,
  output logic [OUT_W-1:0]                    tdata,
  output logic [lanes_of(OUT_W, IN_W)-1:0]    tkeep,
  output logic                                tlast,
  input  logic                                out_ready,
  output logic [15:0]                         word_count
);

  localparam int unsigned LANES = lanes_of(OUT_W, IN_W);
  localparam int unsigned IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  acc_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [OUT_W-1:0] acc, acc_nxt, word;
  logic [LANES-1:0] keep;
  logic             can_load, accept, complete;

  assign in_ready = reset_n && can_load;
  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || idx == LAST_IDX);

  // Word as it would look if the current byte completed it: stored lanes, current byte, then PAD.
  always_comb begin
    word = '0;
    keep = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (IDX_W'(k) < idx) begin
        word[k*IN_W +: IN_W] = acc[k*IN_W +: IN_W];
      end else if (IDX_W'(k) == idx) begin
        word[k*IN_W +: IN_W] = in_data;
      end else begin
        word[k*IN_W +: IN_W] = PAD;
      end
      keep[k] = (IDX_W'(k) <= idx);
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    acc_nxt   = acc;
    if (complete) begin
      state_nxt = EMPTY;
      idx_nxt   = '0;
      acc_nxt   = '0;
    end else if (accept) begin
      state_nxt = PARTIAL;
      idx_nxt   = idx + 1'b1;
      acc_nxt   = word;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= EMPTY;
      idx   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      acc   <= acc_nxt;
    end
  end

  byte_packer_outreg #(
    .OUT_W(OUT_W),
    .LANES(LANES)
  ) u_outreg (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (complete),
    .load_data  (word),
    .load_keep  (keep),
    .load_last  (in_last),
    .out_ready  (out_ready),
    .can_load   (can_load),
    .valid      (valid),
    .tdata      (tdata),
    .tkeep      (tkeep),
    .tlast      (tlast),
    .word_count (word_count)
  );

endmodule
